// File: rtl/spi_apb_tx_sequencer.sv
// APB master that buffers producer bytes and sequences the SPI block: enable CTRL write,
// paced TX data writes, then disable CTRL write. Optional macro: SPI_APB_SEQ_TIMEOUT_EN.
module spi_apb_tx_sequencer #(
  parameter int          FIFO_DEPTH     = 4,
  parameter int          GAP_CYCLES     = 30,
  parameter int          IDLE_CYCLES    = 64,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [9:0]  CTRL_ADDR      = 10'h000,
  parameter logic [9:0]  DATA_ADDR      = 10'h001
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_en,
  input  logic [31:0] cfg_dis,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [9:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_SETUP, S_CFG_ACCESS, S_WAIT_BYTE,
    S_DAT_SETUP, S_DAT_ACCESS, S_GAP, S_DIS_SETUP, S_DIS_ACCESS
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] idle_cnt;
  logic          stop_pend;
  logic          err_q;
  logic [9:0]    paddr_q;
  logic [31:0]   pwdata_q;

  logic in_setup, in_access, access_done, acc_timeout;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign byte_ready = !full;
  assign push       = byte_valid && !full;
  assign pop        = (state_q == S_WAIT_BYTE) && !stop_pend && !empty;

  assign in_setup  = (state_q == S_CFG_SETUP) || (state_q == S_DAT_SETUP) || (state_q == S_DIS_SETUP);
  assign in_access = (state_q == S_CFG_ACCESS) || (state_q == S_DAT_ACCESS) || (state_q == S_DIS_ACCESS);

`ifdef SPI_APB_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] acc_cnt;

  // After TIMEOUT_CYCLES stalled ACCESS cycles the bus is dropped and the transfer abandoned.
  assign acc_timeout = in_access && (acc_cnt == TW'(TIMEOUT_CYCLES));
  assign access_done = in_access && (PREADY || acc_timeout);

  always_ff @(posedge PCLK) begin
    if (PRESET)
      acc_cnt <= '0;
    else if (in_access && !PREADY && !acc_timeout)
      acc_cnt <= acc_cnt + TW'(1);
    else
      acc_cnt <= '0;
  end
`else
  assign acc_timeout = 1'b0;
  assign access_done = in_access && PREADY;
`endif

  assign PSEL    = (in_setup || in_access) && !acc_timeout;
  assign PENABLE = in_access && !acc_timeout;
  assign PWRITE  = PSEL;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DIS_ACCESS) && access_done;
  assign err     = err_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (start) state_d = S_CFG_SETUP;
      S_CFG_SETUP:  state_d = S_CFG_ACCESS;
      S_CFG_ACCESS: if (access_done) state_d = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (stop_pend)                  state_d = S_DIS_SETUP;
        else if (!empty)                state_d = S_DAT_SETUP;
        else if (idle_cnt == IDLE_LAST) state_d = S_DIS_SETUP;
      end
      S_DAT_SETUP:  state_d = S_DAT_ACCESS;
      S_DAT_ACCESS: if (access_done) state_d = (GAP_CYCLES == 0) ? S_WAIT_BYTE : S_GAP;
      S_GAP:        if (gap_cnt == GAP_LAST) state_d = S_WAIT_BYTE;
      S_DIS_SETUP:  state_d = S_DIS_ACCESS;
      S_DIS_ACCESS: if (access_done) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // NOTE: storage array has no reset; the pointers define validity, so flushing resets only them.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= byte_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      gap_cnt   <= '0;
      idle_cnt  <= '0;
      stop_pend <= 1'b0;
      err_q     <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q <= state_d;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      gap_cnt  <= (state_q == S_GAP)       ? gap_cnt + GW'(1)  : '0;
      idle_cnt <= (state_q == S_WAIT_BYTE) ? idle_cnt + IW'(1) : '0;

      // Same-cycle start and stop in IDLE opens a session that closes right after CFG.
      if (state_q == S_IDLE) begin
        if (start) stop_pend <= stop;
      end else if (stop) begin
        stop_pend <= 1'b1;
      end

      if (state_q == S_IDLE && start)
        err_q <= 1'b0;
      else if (in_access && (acc_timeout || (PREADY && PSLVERR)))
        err_q <= 1'b1;

      if (state_d != state_q) begin
        case (state_d)
          S_CFG_SETUP: begin paddr_q <= CTRL_ADDR; pwdata_q <= cfg_en;                 end
          S_DAT_SETUP: begin paddr_q <= DATA_ADDR; pwdata_q <= {24'b0, mem[rd_ptr]};  end
          S_DIS_SETUP: begin paddr_q <= CTRL_ADDR; pwdata_q <= cfg_dis;                end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_apb_tx_sequencer.sv
// Scoreboard bench: stimulus queues the expected APB writes, a negedge monitor checks them
// along with setup spacing, hold stability, PENABLE length and done placement.
module tb_spi_apb_tx_sequencer;

  localparam logic [9:0] CTRL = 10'h000;
  localparam logic [9:0] DATA = 10'h001;
  localparam int GAP  = 30;
  localparam int IDLE = 64;

  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        start = 1'b0, stop = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic [31:0] cfg_en = 32'h3300, cfg_dis = 32'h3700;
  logic        PREADY = 1'b1, PSLVERR = 1'b0;
  logic        byte_ready, PSEL, PENABLE, PWRITE, busy, done, err;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;

  spi_apb_tx_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .stop(stop),
    .cfg_en(cfg_en), .cfg_dis(cfg_dis),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .done(done), .err(err)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];

  int n_vec = 0, n_err = 0;
  int done_cnt = 0, low_run = 0, en_run = 0, last_dis_low = 0;
  int stall_n = 0, acc_cyc = 0;
  bit prev_data = 1'b0, err_on_cfg = 1'b0;
  logic [9:0]  su_a = '0;
  logic [31:0] su_d = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [9:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Slave model: optional wait states on data writes, optional error on the enable write.
  always @(posedge PCLK) begin
    bit in_acc;
    #1;
    in_acc = (PSEL === 1'b1) && (PENABLE === 1'b1);
    acc_cyc = in_acc ? acc_cyc + 1 : 0;
    PREADY  = !(in_acc && PADDR == DATA && acc_cyc <= stall_n);
    PSLVERR = err_on_cfg && in_acc && PADDR == CTRL && PWDATA == cfg_en;
  end

  always @(negedge PCLK) begin
    wr_t w;
    if (PRESET) begin
      low_run   = 1;
      prev_data = 1'b0;
      en_run    = 0;
    end else begin
      if (PSEL && !PENABLE) begin
        check("setup_gap", 32'(low_run >= 1), 1);
        check("pwrite", 32'(PWRITE), 1);
        if (PADDR == DATA && prev_data) check("inter_byte_gap", 32'(low_run >= GAP), 1);
        if (PADDR == CTRL && PWDATA == cfg_dis) last_dis_low = low_run;
        su_a   = PADDR;
        su_d   = PWDATA;
        en_run = 0;
      end
      if (PSEL && PENABLE) begin
        en_run++;
        check("hold_addr", 32'(PADDR), 32'(su_a));
        check("hold_data", PWDATA, su_d);
        if (PREADY) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write", PADDR, PWDATA);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", 32'(PADDR), 32'(w.a));
            check("wr_data", PWDATA, w.d);
          end
          check("penable_len", en_run, (PADDR == DATA) ? stall_n + 1 : 1);
          check("done_on_dis", 32'(done), 32'(PADDR == CTRL && PWDATA == cfg_dis));
          prev_data = (PADDR == DATA);
        end
      end
      low_run = PSEL ? 0 : low_run + 1;
      if (done) done_cnt++;
    end
  end

  // All stimulus tasks start and return at 1 time unit after a rising edge.
  task automatic push(input logic [7:0] b);
    int n = 0;
    while (!byte_ready && n < 300) begin
      @(posedge PCLK); #1;
      n++;
    end
    check("push_ready_timeout", 32'(byte_ready), 1);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge PCLK); #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_start(input bit with_stop);
    start = 1'b1;
    stop  = with_stop;
    @(posedge PCLK); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge PCLK); #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_data_access();
    int n = 0;
    while (!(PSEL && PENABLE && PADDR == DATA) && n < 300) begin
      @(posedge PCLK); #1;
      n++;
    end
    check("data_access_timeout", 32'(PSEL && PENABLE && PADDR == DATA), 1);
  endtask

  initial begin
    int d0;

    // Reset values
    repeat (2) begin @(posedge PCLK); #1; end
    check("rst_psel", 32'(PSEL), 0);
    check("rst_penable", 32'(PENABLE), 0);
    check("rst_pwrite", 32'(PWRITE), 0);
    check("rst_paddr", 32'(PADDR), 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_byte_ready", 32'(byte_ready), 1);
    PRESET = 1'b0;

    // Single byte, latency, gap and auto-disable
    expect_wr(CTRL, 32'h3300); expect_wr(DATA, 32'h56); expect_wr(CTRL, 32'h3700);
    push(8'h56);
    d0 = done_cnt;
    do_start(1'b0);
    check("lat_psel", 32'(PSEL), 1);
    check("lat_penable_low", 32'(PENABLE), 0);
    check("lat_busy", 32'(busy), 1);
    @(posedge PCLK); #1;
    check("lat_penable", 32'(PENABLE), 1);
    wait_idle(500);
    check("done_once", done_cnt - d0, 1);
    check("auto_dis_idle", 32'(last_dis_low >= GAP + IDLE), 1);

    // Five bytes through a 4-deep FIFO
    push(8'h56); push(8'h83); push(8'hA3); push(8'h32);
    check("fifo_full", 32'(byte_ready), 0);
    expect_wr(CTRL, 32'h3300);
    expect_wr(DATA, 32'h56); expect_wr(DATA, 32'h83); expect_wr(DATA, 32'hA3);
    expect_wr(DATA, 32'h32); expect_wr(DATA, 32'hAD);
    expect_wr(CTRL, 32'h3700);
    d0 = done_cnt;
    do_start(1'b0);
    push(8'hAD);
    wait_idle(1500);
    check("done_burst", done_cnt - d0, 1);

    // Five wait states on the data write
    stall_n = 5;
    push(8'h11);
    expect_wr(CTRL, 32'h3300); expect_wr(DATA, 32'h11); expect_wr(CTRL, 32'h3700);
    do_start(1'b0);
    wait_idle(500);
    stall_n = 0;

    // stop during DAT_ACCESS: byte completes, gap, disable; remaining bytes kept
    push(8'h21); push(8'h22); push(8'h23);
    expect_wr(CTRL, 32'h3300); expect_wr(DATA, 32'h21); expect_wr(CTRL, 32'h3700);
    do_start(1'b0);
    wait_data_access();
    stop = 1'b1;
    @(posedge PCLK); #1;
    stop = 1'b0;
    wait_idle(500);
    check("stop_after_gap", 32'(last_dis_low >= GAP), 1);
    check("stop_not_auto", 32'(last_dis_low < GAP + IDLE), 1);
    expect_wr(CTRL, 32'h3300); expect_wr(DATA, 32'h22); expect_wr(DATA, 32'h23);
    expect_wr(CTRL, 32'h3700);
    do_start(1'b0);
    wait_idle(800);

    // PSLVERR on the enable write, then err cleared by the next start
    err_on_cfg = 1'b1;
    push(8'h44);
    expect_wr(CTRL, 32'h3300); expect_wr(DATA, 32'h44); expect_wr(CTRL, 32'h3700);
    do_start(1'b0);
    wait_idle(500);
    check("err_set", 32'(err), 1);
    err_on_cfg = 1'b0;
    expect_wr(CTRL, 32'h3300); expect_wr(CTRL, 32'h3700);
    do_start(1'b0);
    check("err_cleared", 32'(err), 0);
    wait_idle(500);
    check("err_stays_clear", 32'(err), 0);

    // start and stop together: CFG then DIS only, byte retained
    push(8'h55);
    expect_wr(CTRL, 32'h3300); expect_wr(CTRL, 32'h3700);
    do_start(1'b1);
    wait_idle(100);
    check("start_stop_retain", 32'(byte_ready), 1);

    // Reset during GAP flushes the FIFO
    push(8'h61); push(8'h62);
    expect_wr(CTRL, 32'h3300); expect_wr(DATA, 32'h55);
    do_start(1'b0);
    wait_data_access();
    repeat (6) begin @(posedge PCLK); #1; end
    check("gap_queue_drained", exp_q.size(), 0);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("rst_gap_busy", 32'(busy), 0);
    check("rst_gap_psel", 32'(PSEL), 0);
    check("rst_gap_byte_ready", 32'(byte_ready), 1);
    PRESET = 1'b0;
    expect_wr(CTRL, 32'h3300); expect_wr(CTRL, 32'h3700);
    do_start(1'b0);
    wait_idle(500);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
